// File: rtl/pipelined_cpu.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with EX-stage forwarding,
// load-use stall and beq resolved in ID.

module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     pc_o <= '0;
    else if (en) pc_o <= pc_d;
  end
endmodule

module instruction_memory (
  input  logic [7:0]  index,
  output logic [31:0] instr
);
  logic [31:0] memory [0:255];
  assign instr = memory[index];
endmodule

module data_memory (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  index,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] memory [0:31];
  always_ff @(posedge clk) begin
    if (we) memory[index] <= wdata;
  end
  assign rdata = memory[index];
endmodule

module registers (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] data1,
  output logic [31:0] data2
);
  logic [31:0] register [0:31];
  always_ff @(posedge clk) begin
    if (we && rd != 5'd0) register[rd] <= wdata;
  end
  // Same-cycle write-back is visible to the ID read.
  assign data1 = (rs1 == 5'd0) ? 32'd0 : (we && rd == rs1) ? wdata : register[rs1];
  assign data2 = (rs2 == 5'd0) ? 32'd0 : (we && rd == rs2) ? wdata : register[rs2];
endmodule

module ifid (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  // Hold wins over flush so a stalled branch re-evaluates next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o    <= '0;
      instr_o <= '0;
    end else if (!hold) begin
      pc_o    <= pc_i;
      instr_o <= flush ? 32'd0 : instr_i;
    end
  end
endmodule

module idex (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] data1_i, data2_i, imm_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  rs1_i, rs2_i, rd_i,
  output logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o,
  output logic [1:0]  ALUOp_o,
  output logic [31:0] data1_o, data2_o, imm_o,
  output logic [9:0]  funct_o,
  output logic [4:0]  rs1_o, rs2_o, rd_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o} <= '0;
      ALUOp_o <= '0;
      {data1_o, data2_o, imm_o} <= '0;
      funct_o <= '0;
      {rs1_o, rs2_o, rd_o} <= '0;
    end else begin
      RegWrite_o <= bubble ? 1'b0 : RegWrite_i;
      MemtoReg_o <= bubble ? 1'b0 : MemtoReg_i;
      MemRead_o  <= bubble ? 1'b0 : MemRead_i;
      MemWrite_o <= bubble ? 1'b0 : MemWrite_i;
      ALUSrc_o   <= bubble ? 1'b0 : ALUSrc_i;
      ALUOp_o    <= bubble ? 2'b00 : ALUOp_i;
      data1_o <= data1_i;
      data2_o <= data2_i;
      imm_o   <= imm_i;
      funct_o <= funct_i;
      rs1_o   <= rs1_i;
      rs2_o   <= rs2_i;
      rd_o    <= rd_i;
    end
  end
endmodule

module exmem (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
  input  logic [31:0] ALUResult_i, MemData_i,
  input  logic [4:0]  rd_i,
  output logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
  output logic [31:0] ALUResult_o, MemData_o,
  output logic [4:0]  rd_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= '0;
      {ALUResult_o, MemData_o} <= '0;
      rd_o <= '0;
    end else begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
      ALUResult_o <= ALUResult_i;
      MemData_o   <= MemData_i;
      rd_o        <= rd_i;
    end
  end
endmodule

module memwb (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i, MemtoReg_i,
  input  logic [31:0] ALUResult_i, ReadData_i,
  input  logic [4:0]  DATARd_i,
  output logic        RegWrite_o, MemtoReg_o,
  output logic [31:0] ALUResult_o, ReadData_o,
  output logic [4:0]  DATARd_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {RegWrite_o, MemtoReg_o} <= '0;
      {ALUResult_o, ReadData_o} <= '0;
      DATARd_o <= '0;
    end else begin
      {RegWrite_o, MemtoReg_o} <= {RegWrite_i, MemtoReg_i};
      ALUResult_o <= ALUResult_i;
      ReadData_o  <= ReadData_i;
      DATARd_o    <= DATARd_i;
    end
  end
endmodule

module pipelined_cpu (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc, pc_next, if_instr, if_id_pc, if_id_instr;
  logic [31:0] rs1_data, rs2_data, imm, branch_target, wb_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_to_reg, mem_read, mem_write, alu_src, is_beq;
  logic [1:0]  alu_op;
  logic        stall, branch_taken;

  logic        id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src;
  logic [1:0]  id_ex_alu_op;
  logic [31:0] id_ex_data1, id_ex_data2, id_ex_imm;
  logic [9:0]  id_ex_funct;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result;

  logic        ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_read, ex_mem_mem_write;
  logic [31:0] ex_mem_alu, ex_mem_data, dmem_rdata, mem_read_data;
  logic [4:0]  ex_mem_rd;

  logic        mem_wb_reg_write, mem_wb_mem_to_reg;
  logic [31:0] mem_wb_alu, mem_wb_read_data;
  logic [4:0]  mem_wb_rd;

  // IF
  assign pc_next = branch_taken ? branch_target : pc + 32'd4;

  pc_reg PC (.clk(clk_i), .rst(rst_i), .en(start_i && !stall), .pc_d(pc_next), .pc_o(pc));

  instruction_memory Instruction_Memory (.index(pc[9:2]), .instr(if_instr));

  // While not running, fetch feeds bubbles so the held PC is not re-issued.
  ifid IFID (
    .clk(clk_i), .rst(rst_i), .hold(stall), .flush(branch_taken || !start_i),
    .pc_i(pc), .instr_i(if_instr), .pc_o(if_id_pc), .instr_o(if_id_instr)
  );

  // ID
  assign opcode = if_id_instr[6:0];
  assign rd     = if_id_instr[11:7];
  assign funct3 = if_id_instr[14:12];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign funct7 = if_id_instr[31:25];

  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    is_beq     = 1'b0;
    imm        = '0;
    case (opcode)
      OP_R: begin
        if (funct3 == 3'b111 || funct3 == 3'b100 || funct3 == 3'b001 ||
            (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20 || funct7 == 7'h01))) begin
          reg_write = 1'b1;
          alu_op    = 2'b10;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000 || (funct3 == 3'b101 && funct7 == 7'h20)) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = 2'b11;
          imm       = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          mem_read   = 1'b1;
          alu_src    = 1'b1;
          imm        = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm       = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
        end
      end
      OP_BRANCH: is_beq = (funct3 == 3'b000);
      default: ;
    endcase
  end

  registers Registers (
    .clk(clk_i), .we(mem_wb_reg_write), .rd(mem_wb_rd), .wdata(wb_data),
    .rs1(rs1), .rs2(rs2), .data1(rs1_data), .data2(rs2_data)
  );

  assign stall         = id_ex_mem_read && (id_ex_rd == rs1 || id_ex_rd == rs2);
  assign branch_target = if_id_pc + {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                                     if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign branch_taken  = is_beq && (rs1_data == rs2_data) && !stall;

  idex IDEX (
    .clk(clk_i), .rst(rst_i), .bubble(stall),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .MemRead_i(mem_read),
    .MemWrite_i(mem_write), .ALUSrc_i(alu_src), .ALUOp_i(alu_op),
    .data1_i(rs1_data), .data2_i(rs2_data), .imm_i(imm), .funct_i({funct7, funct3}),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .RegWrite_o(id_ex_reg_write), .MemtoReg_o(id_ex_mem_to_reg), .MemRead_o(id_ex_mem_read),
    .MemWrite_o(id_ex_mem_write), .ALUSrc_o(id_ex_alu_src), .ALUOp_o(id_ex_alu_op),
    .data1_o(id_ex_data1), .data2_o(id_ex_data2), .imm_o(id_ex_imm), .funct_o(id_ex_funct),
    .rs1_o(id_ex_rs1), .rs2_o(id_ex_rs2), .rd_o(id_ex_rd)
  );

  // EX: forwarding, EX/MEM before MEM/WB
  always_comb begin
    fwd_a = id_ex_data1;
    fwd_b = id_ex_data2;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1)      fwd_a = ex_mem_alu;
    else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1) fwd_a = wb_data;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2)      fwd_b = ex_mem_alu;
    else if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2) fwd_b = wb_data;
  end

  assign alu_b = id_ex_alu_src ? id_ex_imm : fwd_b;

  always_comb begin
    alu_result = fwd_a + alu_b;
    case (id_ex_alu_op)
      2'b10: begin
        case (id_ex_funct[2:0])
          3'b111: alu_result = fwd_a & alu_b;
          3'b100: alu_result = fwd_a ^ alu_b;
          3'b001: alu_result = fwd_a << alu_b[4:0];
          default: begin
            if (id_ex_funct[9:3] == 7'h20)      alu_result = fwd_a - alu_b;
            else if (id_ex_funct[9:3] == 7'h01) alu_result = fwd_a * alu_b;
          end
        endcase
      end
      2'b11: if (id_ex_funct[2:0] == 3'b101) alu_result = $signed(fwd_a) >>> alu_b[4:0];
      default: ;
    endcase
  end

  exmem EXMEM (
    .clk(clk_i), .rst(rst_i),
    .RegWrite_i(id_ex_reg_write), .MemtoReg_i(id_ex_mem_to_reg),
    .MemRead_i(id_ex_mem_read), .MemWrite_i(id_ex_mem_write),
    .ALUResult_i(alu_result), .MemData_i(fwd_b), .rd_i(id_ex_rd),
    .RegWrite_o(ex_mem_reg_write), .MemtoReg_o(ex_mem_mem_to_reg),
    .MemRead_o(ex_mem_mem_read), .MemWrite_o(ex_mem_mem_write),
    .ALUResult_o(ex_mem_alu), .MemData_o(ex_mem_data), .rd_o(ex_mem_rd)
  );

  // MEM
  data_memory Data_Memory (
    .clk(clk_i), .we(ex_mem_mem_write), .index(ex_mem_alu[6:2]),
    .wdata(ex_mem_data), .rdata(dmem_rdata)
  );

  assign mem_read_data = ex_mem_mem_read ? dmem_rdata : 32'd0;

  memwb MEMWB (
    .clk(clk_i), .rst(rst_i),
    .RegWrite_i(ex_mem_reg_write), .MemtoReg_i(ex_mem_mem_to_reg),
    .ALUResult_i(ex_mem_alu), .ReadData_i(mem_read_data), .DATARd_i(ex_mem_rd),
    .RegWrite_o(mem_wb_reg_write), .MemtoReg_o(mem_wb_mem_to_reg),
    .ALUResult_o(mem_wb_alu), .ReadData_o(mem_wb_read_data), .DATARd_o(mem_wb_rd)
  );

  // WB
  assign wb_data = mem_wb_mem_to_reg ? mem_wb_read_data : mem_wb_alu;

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: preloads a program, steps the pipeline and
// checks PC, pipeline registers, register file and data memory hierarchically.

module tb_pipelined_cpu;
  logic clk = 1'b0;
  logic rst;
  logic start;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [15];
  logic [31:0] exp_reg [14];

  pipelined_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string phase);
    for (int i = 1; i < 14; i++)
      check($sformatf("%s_x%0d", phase, i), dut.Registers.register[i], exp_reg[i]);
    check({phase, "_dmem0"}, dut.Data_Memory.memory[0], 32'd5);
    check({phase, "_dmem1"}, dut.Data_Memory.memory[1], 32'd7);
  endtask

  initial begin
    prog = '{32'h00a00093,   // 00 addi x1,x0,10
             32'h00108133,   // 04 add  x2,x1,x1
             32'h401101b3,   // 08 sub  x3,x2,x1
             32'h00002203,   // 0C lw   x4,0(x0)
             32'h004202b3,   // 10 add  x5,x4,x4
             32'h00700313,   // 14 addi x6,x0,7
             32'h00602223,   // 18 sw   x6,4(x0)
             32'h00402383,   // 1C lw   x7,4(x0)
             32'h00000463,   // 20 beq  x0,x0,+8
             32'h00100413,   // 24 addi x8,x0,1 (skipped)
             32'hff000493,   // 28 addi x9,x0,-16
             32'h4024d513,   // 2C srai x10,x9,2
             32'h00200613,   // 30 addi x12,x0,2
             32'h00c095b3,   // 34 sll  x11,x1,x12
             32'h021086b3};  // 38 mul  x13,x1,x1
    exp_reg = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd5, 32'd10, 32'd7, 32'd7,
                32'd0, 32'hfffffff0, 32'hfffffffc, 32'd40, 32'd2, 32'd100};

    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
    for (int i = 0; i < 15; i++)  dut.Instruction_Memory.memory[i] = prog[i];
    for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
    dut.Data_Memory.memory[0] = 32'd5;

    repeat (2) step();
    check("rst_pc", dut.PC.pc_o, 32'd0);
    check("rst_idex_regwrite", dut.IDEX.RegWrite_o, 32'd0);
    check("rst_idex_aluop", dut.IDEX.ALUOp_o, 32'd0);
    check("rst_exmem_memwrite", dut.EXMEM.MemWrite_o, 32'd0);
    check("rst_memwb_regwrite", dut.MEMWB.RegWrite_o, 32'd0);

    rst = 1'b0;
    repeat (3) step();
    check("start_low_pc_held", dut.PC.pc_o, 32'd0);
    check("start_low_no_write", dut.Registers.register[1], 32'd0);

    start = 1'b1;
    step();                                              // edge 1
    check("e1_pc", dut.PC.pc_o, 32'h4);
    check("e1_ifid_pc", dut.IFID.pc_o, 32'h0);
    check("e1_ifid_instr", dut.IFID.instr_o, prog[0]);
    repeat (2) step();                                   // edge 3
    check("e3_exmem_addi_result", dut.EXMEM.ALUResult_o, 32'd10);
    repeat (2) step();                                   // edge 5
    check("e5_pc", dut.PC.pc_o, 32'h14);
    check("e5_idex_memread", dut.IDEX.MemRead_o, 32'd1);
    step();                                              // edge 6: load-use stall
    check("stall_pc_held", dut.PC.pc_o, 32'h14);
    check("stall_ifid_held", dut.IFID.instr_o, prog[4]);
    check("stall_bubble_regwrite", dut.IDEX.RegWrite_o, 32'd0);
    check("stall_bubble_memread", dut.IDEX.MemRead_o, 32'd0);
    step();                                              // edge 7
    check("e7_pc", dut.PC.pc_o, 32'h18);
    repeat (3) step();                                   // edge 10
    check("e10_pc", dut.PC.pc_o, 32'h24);
    check("e10_ifid_beq", dut.IFID.instr_o, prog[8]);
    step();                                              // edge 11: branch taken
    check("branch_pc_target", dut.PC.pc_o, 32'h28);
    check("branch_flush_nop", dut.IFID.instr_o, 32'd0);
    repeat (19) step();                                  // edge 30
    check("e30_pc", dut.PC.pc_o, 32'h74);
    check_regs("run1");
    repeat (5) step();
    check("tail_pc", dut.PC.pc_o, 32'h88);
    check("tail_x13", dut.Registers.register[13], 32'd100);
    check("tail_x8", dut.Registers.register[8], 32'd0);

    // Reset mid-run, then confirm the program restarts from address 0.
    rst = 1'b1;
    #1;
    check("async_rst_pc", dut.PC.pc_o, 32'd0);
    for (int i = 1; i < 32; i++) dut.Registers.register[i] = 32'd0;
    dut.Data_Memory.memory[1] = 32'd0;
    step();
    rst = 1'b0;
    step();                                              // edge 1
    check("restart_ifid_pc", dut.IFID.pc_o, 32'h0);
    check("restart_pc", dut.PC.pc_o, 32'h4);
    repeat (2) step();                                   // edge 3: addi x1 in MEM
    check("inflight_exmem_regwrite", dut.EXMEM.RegWrite_o, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_clears_exmem", dut.EXMEM.RegWrite_o, 32'd0);
    check("rst_clears_memwb", dut.MEMWB.RegWrite_o, 32'd0);
    repeat (3) step();
    check("no_write_after_rst_x1", dut.Registers.register[1], 32'd0);
    check("no_write_after_rst_x2", dut.Registers.register[2], 32'd0);
    check("rst_keeps_dmem0", dut.Data_Memory.memory[0], 32'd5);
    rst = 1'b0;
    repeat (30) step();
    check_regs("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_cpu.md
PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 SHALL have no parameters; memory sizes fixed (instruction 256 x 32 bit, data 32 x 32 bit, register file 32 x 32 bit).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 start_i  input  1  run enable; PC advances only while high.
REQ-005 SHALL have no other ports; state is observed hierarchically.
REQ-006 Observable state SHALL be at these paths: PC.pc_o; Instruction_Memory.memory[0:255]; Data_Memory.memory[0:31]; Registers.register[0:31].
REQ-007 Pipeline registers SHALL be instances IFID, IDEX, EXMEM, MEMWB, with outputs named as the bench initialises them (e.g. IDEX.ALUOp_o 2 bit, IDEX.funct_o 10 bit, EXMEM.ALUResult_o, MEMWB.DATARd_o).

Function
REQ-008 5-stage in-order pipeline SHALL be used: IF, ID, EX, MEM, WB.
REQ-009 ISA SHALL be RV32I subset:
- R-type (op 0110011): and (f3 111), xor (100), sll (001), add (000, f7 0000000), sub (000, f7 0100000), mul (000, f7 0000001; low 32 bits).
- addi (op 0010011, f3 000); srai (op 0010011, f3 101, imm[11:5]=0100000; shift amount = imm[4:0], arithmetic).
- lw (op 0000011, f3 010); sw (op 0100011, f3 010); beq (op 1100011, f3 000).
REQ-010 All-zero word and undefined opcodes SHALL act as NOP: no register write, no memory write, no branch.
REQ-011 Immediates SHALL be sign-extended to 32 bits.
REQ-012 Instruction fetch SHALL use word index PC[9:2]; PC+4 wraps modulo 2^32.
REQ-013 Data memory SHALL be word-addressed by ALUResult[6:2]; sw writes on clock edge; lw reads combinationally.
REQ-014 Register file: x0 reads 0 and ignores writes; write on rising edge in WB; a same-cycle WB write to an ID source SHALL be bypassed to the ID read.
REQ-015 Forwarding unit SHALL supply EX operands: EX/MEM result has priority over MEM/WB; only when producer RegWrite=1 and Rd!=0.
REQ-016 Load-use hazard (IDEX.MemRead=1, IDEX.Rd equal to ID rs1 or rs2) SHALL stall PC and IFID for 1 cycle and insert a bubble (all IDEX control 0).
REQ-017 beq SHALL resolve in ID: compare rs1/rs2 register-file values; if equal, PC <= IFID.PC + (sign-extended B-imm << 1) and IFID flushed to NOP (1-cycle penalty).
REQ-018 Branch operands in ID SHALL NOT be forwarded from EX/MEM; program must space dependences.
REQ-019 When stall and taken branch coincide, stall SHALL take precedence; branch re-evaluates next cycle.
REQ-020 start_i=0 SHALL hold PC; pipeline registers keep clocking.

Reset
REQ-021 rst_i=1 SHALL asynchronously set PC to 0.
REQ-022 rst_i=1 SHALL clear all pipeline-register control bits (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp).
REQ-023 Reset SHALL NOT clear instruction memory, data memory or the register file.
REQ-024 Reset mid-operation SHALL discard in-flight instructions; no write occurs after rst_i rises.
REQ-025 After release, fetch SHALL restart at address 0 on the first rising edge with start_i=1.

Verification
REQ-026 Sequential ops: mem[0]=5; program addi x1,x0,10; add x2,x1,x1 -> x1=10, x2=20 (EX/MEM forwarding); sub x3,x2,x1 -> x3=10.
REQ-027 Load-use: lw x4,0(x0); add x5,x4,x4 -> x5=10; exactly one stall cycle, PC held one cycle.
REQ-028 Store: addi x6,x0,7; sw x6,4(x0) -> Data_Memory.memory[1]=7; lw x7,4(x0) -> x7=7.
REQ-029 Branch: beq x0,x0,+8 followed by addi x8,x0,1 -> x8 stays 0; one flush; PC jumps to branch PC+8.
REQ-030 Shifts/mul: x9=-16; srai x10,x9,2 -> x10=-4; sll x11,x1(10),x12(2) -> 40; mul x13,x1,x1 -> 100; all-zero memory tail -> PC +4 per cycle, no state change.
